// File: rtl/packetizer_da_multi.sv
// packetizer_da_multi: appends the return dst/vc to a payload word and serialises the
//   result into head/body/tail flits for one NoC router port.
// Latency: the head flit appears one cycle after the payload is accepted. Every later
//   flit follows one cycle after the previous flit transfers.
// Backpressure: a flit is held stable while ready_in is low. ready_out is high when idle,
//   or during the cycle in which the tail transfers, so back-to-back packets have no bubble.
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   data_in/valid_in/ready_out     payload side (ready/valid)
//   dst_in, vc_in                  routing info for every flit of the packet
//   ret_dst_in, ret_vc_in          return address, packed above the payload
//   data_out/valid_out/ready_in    flit side (ready/valid)
module packetizer_da_multi #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12,
  parameter int WIDTH_OUT        = 36,
  parameter int MAX_FLITS        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_IN-1:0]         data_in,
  input  logic                        valid_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  input  logic [ADDRESS_WIDTH-1:0]    ret_dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] ret_vc_in,
  output logic                        ready_out,
  output logic [WIDTH_OUT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in
);

  // Packed word width, flit payload width and head-flit payload width.
  localparam int PW     = WIDTH_IN + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
  localparam int FP     = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH;
  localparam int HP_RAW = FP - ADDRESS_WIDTH;
  // Clamped so that slice widths stay legal long enough to report the real error.
  localparam int HP     = (HP_RAW < 1) ? 1 : HP_RAW;
  localparam int NUM_FLITS = 1 + ((PW > HP) ? (PW - HP + FP - 1) / FP : 0);
  localparam int IDX_W  = (MAX_FLITS > 2) ? $clog2(MAX_FLITS) : 1;
  // The padded word covers every index the counter can hold, so the body select never
  // leaves the vector, and bits above PW read as zero (padding for the last flit).
  localparam int PAD_W  = HP + (2 ** IDX_W) * FP;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLITS - 1);

  if (HP_RAW < 1) begin : g_hp_check
    $error("packetizer_da_multi: head flit has no room for payload (HP < 1)");
  end
  if (NUM_FLITS > MAX_FLITS) begin : g_flit_check
    $error("packetizer_da_multi: NUM_FLITS exceeds MAX_FLITS");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [PW-1:0]               p_q;
  logic [ADDRESS_WIDTH-1:0]    dst_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;

  logic             accept;
  logic             last;
  logic             xfer;
  logic [PAD_W-1:0] p_pad;
  logic [IDX_W-1:0] body_sel;
  logic [FP-1:0]    payload;

  // Next-state and handshake logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last      = (idx_q == LAST_IDX);
    xfer      = (state_q == SEND) & ready_in;
    // A new payload can be taken during the tail transfer, giving zero-bubble operation.
    ready_out = ~rst & ((state_q == IDLE) | (xfer & last));
    accept    = valid_in & ready_out;

    if (accept) begin
      state_d = SEND;
      idx_d   = '0;
    end else if (xfer) begin
      if (last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Flit formatting from the held registers only; inputs are ignored while sending.
  always_comb begin
    p_pad          = '0;
    p_pad[PW-1:0]  = p_q;
    body_sel       = idx_q - 1'b1;
    payload        = '0;
    if (idx_q == '0) begin
      payload = {dst_q, p_pad[HP-1:0]};
    end else begin
      payload = p_pad[HP + int'(body_sel) * FP +: FP];
    end

    valid_out = (state_q == SEND);
    data_out  = '0;
    if (state_q == SEND) begin
      data_out = {1'b1, (idx_q == '0), last, vc_q, payload};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      p_q     <= '0;
      dst_q   <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        p_q   <= {ret_dst_in, ret_vc_in, data_in};
        dst_q <= dst_in;
        vc_q  <= vc_in;
      end
    end
  end

endmodule

// File: tb/tb_packetizer_da_multi.sv
// Bench for packetizer_da_multi: one instance with default widths (single-flit packets)
// and one with WIDTH_IN=64 (three flits). Expected flits come from a queue-based model
// that slices the packed word with plain shifts.
module tb_packetizer_da_multi;

  localparam int HP = 28;
  localparam int FP = 32;

  logic clk;
  logic rst;

  // Instance a: default widths.
  logic [11:0] a_data;
  logic        a_valid, a_vc, a_rvc, a_rdy_out, a_vout, a_rdy_in;
  logic [3:0]  a_dst, a_rdst;
  logic [35:0] a_dout;

  // Instance b: WIDTH_IN = 64.
  logic [63:0] b_data;
  logic        b_valid, b_vc, b_rvc, b_rdy_out, b_vout, b_rdy_in;
  logic [3:0]  b_dst, b_rdst;
  logic [35:0] b_dout;

  int n_tests = 0;
  int n_fail  = 0;

  packetizer_da_multi u_a (
    .clk(clk), .rst(rst), .data_in(a_data), .valid_in(a_valid), .dst_in(a_dst),
    .vc_in(a_vc), .ret_dst_in(a_rdst), .ret_vc_in(a_rvc), .ready_out(a_rdy_out),
    .data_out(a_dout), .valid_out(a_vout), .ready_in(a_rdy_in)
  );

  packetizer_da_multi #(.WIDTH_IN(64)) u_b (
    .clk(clk), .rst(rst), .data_in(b_data), .valid_in(b_valid), .dst_in(b_dst),
    .vc_in(b_vc), .ret_dst_in(b_rdst), .ret_vc_in(b_rvc), .ready_out(b_rdy_out),
    .data_out(b_dout), .valid_out(b_vout), .ready_in(b_rdy_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nflits(input int pw);
    return 1 + ((pw > HP) ? (pw - HP + FP - 1) / FP : 0);
  endfunction

  function automatic logic [127:0] mkp64(input logic [63:0] d, input logic [3:0] rd, input logic rv);
    return {59'd0, rd, rv, d};
  endfunction

  function automatic logic [35:0] mk_flit(input logic [127:0] p, input int pw,
                                          input logic [3:0] dst, input logic vc, input int k);
    logic [127:0] pay;
    int nf;
    nf = nflits(pw);
    if (k == 0) pay = ({124'd0, dst} << HP) | (p & ((128'd1 << HP) - 128'd1));
    else        pay = (p >> (HP + (k - 1) * FP)) & 128'hFFFF_FFFF;
    return {1'b1, (k == 0), (k == nf - 1), vc, pay[31:0]};
  endfunction

  task automatic set_b(input logic v, input logic [63:0] d, input logic [3:0] dst,
                       input logic vc, input logic [3:0] rd, input logic rv, input logic rin);
    b_valid = v; b_data = d; b_dst = dst; b_vc = vc; b_rdst = rd; b_rvc = rv; b_rdy_in = rin;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_data = '0; a_dst = '0; a_vc = 0; a_rdst = '0; a_rvc = 0; a_rdy_in = 1;
    set_b(0, '0, '0, 0, '0, 0, 1);
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    a_valid = 1; b_valid = 1;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (a_rdy_out !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready_out: got %b want 0", a_rdy_out); end
    n_tests++;
    if (b_rdy_out !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready_out: got %b want 0", b_rdy_out); end
    n_tests++;
    if (a_vout !== 1'b0 || a_dout !== 36'd0) begin n_fail++; $display("FAIL rst_a_out: got v=%b d=%h want 0/0", a_vout, a_dout); end
    n_tests++;
    if (b_vout !== 1'b0 || b_dout !== 36'd0) begin n_fail++; $display("FAIL rst_b_out: got v=%b d=%h want 0/0", b_vout, b_dout); end
    n_tests++;
    a_valid = 0; b_valid = 0;
    @(posedge clk); #1 rst = 0;
    #1;
    if (a_rdy_out !== 1'b1) begin n_fail++; $display("FAIL post_rst_a_ready: got %b want 1", a_rdy_out); end
    n_tests++;
    if (b_rdy_out !== 1'b1) begin n_fail++; $display("FAIL post_rst_b_ready: got %b want 1", b_rdy_out); end
    n_tests++;
    if (b_vout !== 1'b0) begin n_fail++; $display("FAIL post_rst_b_valid: got %b want 0", b_vout); end
    n_tests++;
  endtask

  task automatic test_single_flit();
    logic [35:0] exp_m;
    do_reset();
    a_data = 12'hABC; a_dst = 4'd5; a_vc = 1; a_rdst = 4'd3; a_rvc = 0; a_rdy_in = 1; a_valid = 1;
    exp_m = mk_flit({111'd0, a_rdst, a_rvc, a_data}, 17, a_dst, a_vc, 0);
    #1;
    if (a_vout !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid: got %b want 0", a_vout); end
    n_tests++;
    @(posedge clk); #1;
    a_valid = 0;
    #1;
    if (a_dout !== 36'hF_5000_6ABC) begin n_fail++; $display("FAIL single_flit: got %h want %h", a_dout, 36'hF_5000_6ABC); end
    n_tests++;
    if (a_dout !== exp_m) begin n_fail++; $display("FAIL single_flit_model: got %h want %h", a_dout, exp_m); end
    n_tests++;
    if (a_vout !== 1'b1 || a_rdy_out !== 1'b1) begin n_fail++; $display("FAIL single_hs: got v=%b r=%b want 1/1", a_vout, a_rdy_out); end
    n_tests++;
    @(posedge clk); #2;
    if (a_vout !== 1'b0 || a_dout !== 36'd0) begin n_fail++; $display("FAIL single_idle: got v=%b d=%h want 0/0", a_vout, a_dout); end
    n_tests++;
  endtask

  task automatic test_three_flit();
    logic [35:0] lit [3];
    logic [127:0] p;
    lit[0] = 36'hC_A9AB_CDEF; lit[1] = 36'h8_1234_5678; lit[2] = 36'hA_0000_0130;
    do_reset();
    set_b(1, 64'h0123_4567_89AB_CDEF, 4'hA, 0, 4'h9, 1, 1);
    p = mkp64(b_data, b_rdst, b_rvc);
    @(posedge clk); #1;
    b_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (b_dout !== lit[k]) begin n_fail++; $display("FAIL three_flit_%0d: got %h want %h", k, b_dout, lit[k]); end
      n_tests++;
      if (b_dout !== mk_flit(p, 69, 4'hA, 0, k)) begin n_fail++; $display("FAIL three_model_%0d: got %h want %h", k, b_dout, mk_flit(p, 69, 4'hA, 0, k)); end
      n_tests++;
      if (b_dout[34] !== (k == 0) || b_dout[33] !== (k == 2)) begin n_fail++; $display("FAIL three_ht_%0d: got %b%b", k, b_dout[34], b_dout[33]); end
      n_tests++;
      @(posedge clk); #1;
    end
    #1;
    if (b_vout !== 1'b0) begin n_fail++; $display("FAIL three_done: got %b want 0", b_vout); end
    n_tests++;
  endtask

  task automatic test_backpressure();
    logic [35:0] f [3];
    logic        rin [5];
    int          want [5];
    logic [127:0] p;
    rin = '{1, 0, 0, 1, 1};
    want = '{0, 1, 1, 1, 2};
    do_reset();
    set_b(1, 64'hFEDC_BA98_7654_3210, 4'h3, 1, 4'h6, 0, 1);
    p = mkp64(b_data, b_rdst, b_rvc);
    for (int k = 0; k < 3; k++) f[k] = mk_flit(p, 69, 4'h3, 1, k);
    @(posedge clk); #1;
    b_valid = 0;
    for (int c = 0; c < 5; c++) begin
      b_rdy_in = rin[c];
      #1;
      if (b_vout !== 1'b1 || b_dout !== f[want[c]]) begin
        n_fail++; $display("FAIL bp_cycle_%0d: got v=%b d=%h want 1/%h", c, b_vout, b_dout, f[want[c]]);
      end
      n_tests++;
      if (b_rdy_out !== (want[c] == 2 && rin[c])) begin n_fail++; $display("FAIL bp_ready_%0d: got %b", c, b_rdy_out); end
      n_tests++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] e [8];
    logic        r [8];
    logic [127:0] p0, p1;
    do_reset();
    p0 = mkp64(64'h1111_2222_3333_4444, 4'h1, 1);
    p1 = mkp64(64'h5555_6666_7777_8888, 4'h2, 0);
    e[0] = '0; r[0] = 1; e[7] = '0; r[7] = 1;
    for (int k = 0; k < 3; k++) begin
      e[1 + k] = mk_flit(p0, 69, 4'h7, 0, k);
      e[4 + k] = mk_flit(p1, 69, 4'hC, 1, k);
      r[1 + k] = (k == 2); r[4 + k] = (k == 2);
    end
    for (int c = 0; c < 8; c++) begin
      if (c == 0) set_b(1, 64'h1111_2222_3333_4444, 4'h7, 0, 4'h1, 1, 1);
      if (c == 1) set_b(1, 64'h5555_6666_7777_8888, 4'hC, 1, 4'h2, 0, 1);
      if (c == 4) b_valid = 0;
      #1;
      if (b_dout !== e[c] || b_vout !== (c >= 1 && c <= 6) || b_rdy_out !== r[c]) begin
        n_fail++; $display("FAIL b2b_cycle_%0d: got v=%b r=%b d=%h want r=%b d=%h", c, b_vout, b_rdy_out, b_dout, r[c], e[c]);
      end
      n_tests++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [127:0] p;
    do_reset();
    set_b(1, 64'hAAAA_BBBB_CCCC_DDDD, 4'h4, 1, 4'h8, 1, 1);
    @(posedge clk); #1;
    b_valid = 0;
    #1;
    if (b_dout[34] !== 1'b1 || b_vout !== 1'b1) begin n_fail++; $display("FAIL midrst_head: got v=%b h=%b", b_vout, b_dout[34]); end
    n_tests++;
    @(posedge clk); #1;
    rst = 1;
    #1;
    if (b_rdy_out !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b want 0", b_rdy_out); end
    n_tests++;
    @(posedge clk); #1;
    rst = 0;
    set_b(1, 64'h0F0F_0F0F_0F0F_0F0F, 4'hE, 0, 4'h5, 0, 1);
    p = mkp64(b_data, b_rdst, b_rvc);
    #1;
    if (b_vout !== 1'b0 || b_dout !== 36'd0) begin n_fail++; $display("FAIL midrst_flush: got v=%b d=%h want 0/0", b_vout, b_dout); end
    n_tests++;
    @(posedge clk); #1;
    b_valid = 0;
    #1;
    if (b_dout !== mk_flit(p, 69, 4'hE, 0, 0)) begin n_fail++; $display("FAIL midrst_new_head: got %h want %h", b_dout, mk_flit(p, 69, 4'hE, 0, 0)); end
    n_tests++;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_valid();
    logic [127:0] p;
    do_reset();
    set_b(1, 64'h1357_9BDF_0246_8ACE, 4'h2, 0, 4'hB, 1, 1);
    p = mkp64(b_data, b_rdst, b_rvc);
    @(posedge clk); #1;
    b_valid = 0;
    @(posedge clk); #1;
    set_b(1, 64'hDEAD_BEEF_DEAD_BEEF, 4'hF, 1, 4'hF, 1, 1);
    #1;
    if (b_rdy_out !== 1'b0) begin n_fail++; $display("FAIL ign_ready_body: got %b want 0", b_rdy_out); end
    n_tests++;
    if (b_dout !== mk_flit(p, 69, 4'h2, 0, 1)) begin n_fail++; $display("FAIL ign_body: got %h want %h", b_dout, mk_flit(p, 69, 4'h2, 0, 1)); end
    n_tests++;
    @(posedge clk); #1;
    b_valid = 0;
    #1;
    if (b_dout !== mk_flit(p, 69, 4'h2, 0, 2)) begin n_fail++; $display("FAIL ign_tail: got %h want %h", b_dout, mk_flit(p, 69, 4'h2, 0, 2)); end
    n_tests++;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #2;
      if (b_vout !== 1'b0) begin n_fail++; $display("FAIL ign_extra_%0d: got valid %b want 0", c, b_vout); end
      n_tests++;
    end
  endtask

  task automatic test_random();
    logic [35:0]  q [$];
    logic [127:0] p;
    logic         exp_rdy;
    logic [35:0]  exp_d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_b($urandom_range(0, 2) != 0, {$urandom, $urandom}, 4'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (q.size() == 0) || (q.size() == 1 && b_rdy_in);
      exp_d   = (q.size() != 0) ? q[0] : 36'd0;
      if (b_rdy_out !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready_%0d: got %b want %b", c, b_rdy_out, exp_rdy); end
      n_tests++;
      if (b_vout !== (q.size() != 0) || b_dout !== exp_d) begin
        n_fail++; $display("FAIL rnd_flit_%0d: got v=%b d=%h want d=%h", c, b_vout, b_dout, exp_d);
      end
      n_tests++;
      if (q.size() != 0 && b_rdy_in) void'(q.pop_front());
      if (b_valid && exp_rdy) begin
        p = mkp64(b_data, b_rdst, b_rvc);
        for (int k = 0; k < nflits(69); k++) q.push_back(mk_flit(p, 69, b_dst, b_vc, k));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_flit();
    test_three_flit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    test_ignore_valid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
